// File: rtl/logic_pkg.sv
// Shared definitions for the pipelined logic unit.
//   op_t     : 3-bit opcode
//   OP_*     : opcode values (AND, OR, XOR, NAND, NOR, XNOR, NOT, NEG)
//   flags_t  : status flags derived from a result {zero, neg, par, ovf}
package logic_pkg;

  typedef logic [2:0] op_t;

  localparam op_t OP_AND  = 3'd0;
  localparam op_t OP_OR   = 3'd1;
  localparam op_t OP_XOR  = 3'd2;
  localparam op_t OP_NAND = 3'd3;
  localparam op_t OP_NOR  = 3'd4;
  localparam op_t OP_XNOR = 3'd5;
  localparam op_t OP_NOT  = 3'd6;
  localparam op_t OP_NEG  = 3'd7;

  typedef struct packed {
    logic zero;
    logic neg;
    logic par;
    logic ovf;
  } flags_t;

endpackage

// File: rtl/logic_core.sv
// Purely combinational bitwise / negate unit.
// Ports:
//   a, b  : WIDTH-bit operands (b unused by NOT and NEG)
//   op    : opcode (logic_pkg::op_t)
//   res   : WIDTH-bit result
//   flags : zero / neg / parity / overflow of res
module logic_core
  import logic_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_t              op,
  output logic [WIDTH-1:0] res,
  output flags_t           flags
);

  // Most-negative two's-complement value: negating it gives itself back.
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  always_comb begin
    res = '0;
    case (op)
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_NAND: res = ~(a & b);
      OP_NOR:  res = ~(a | b);
      OP_XNOR: res = ~(a ^ b);
      OP_NOT:  res = ~a;
      OP_NEG:  res = ~a + WIDTH'(1);
      default: res = '0;
    endcase
  end

  always_comb begin
    flags.zero = (res == '0);
    flags.neg  = res[WIDTH-1];
    flags.par  = ^res;
    flags.ovf  = (op == OP_NEG) && (a == MIN_NEG);
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined logic unit with valid/ready handshake on both sides.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : input handshake; in_a, in_b, in_op are the payload
//   out_valid/out_ready : output handshake; out_res plus flags are the payload
//   out_zero/neg/par/ovf: flags of out_res
//   op_count            : saturating count of completed output transfers
// Stage 1 holds operands, stage 2 holds the computed result and flags.
module logic_unit_pipe
  import logic_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_par,
  output logic             out_ovf,
  output logic [CNT_W-1:0] op_count
);

  // Stage 1
  logic             s1_v_q, s1_v_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  op_t              s1_op_q, s1_op_d;

  // Stage 2
  logic             s2_v_q, s2_v_d;
  logic [WIDTH-1:0] s2_res_q, s2_res_d;
  flags_t           s2_flags_q, s2_flags_d;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             s1_adv, s2_adv;
  logic [WIDTH-1:0] core_res;
  flags_t           core_flags;

  logic_core #(.WIDTH(WIDTH)) u_core (
    .a     (s1_a_q),
    .b     (s1_b_q),
    .op    (s1_op_q),
    .res   (core_res),
    .flags (core_flags)
  );

  // A stage may load whenever it is empty or its content moves on this cycle.
  // in_ready therefore depends combinationally on out_ready.
  always_comb begin
    s2_adv = !s2_v_q || out_ready;
    s1_adv = !s1_v_q || s2_adv;
  end

  always_comb begin
    s1_v_d     = s1_v_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_op_d    = s1_op_q;
    s2_v_d     = s2_v_q;
    s2_res_d   = s2_res_q;
    s2_flags_d = s2_flags_q;
    cnt_d      = cnt_q;

    if (s1_adv) begin
      s1_v_d = in_valid;
      if (in_valid) begin
        s1_a_d  = in_a;
        s1_b_d  = in_b;
        s1_op_d = in_op;
      end
    end

    // On a bubble only the valid bit clears; result and flags keep their
    // last value so the output bus does not toggle needlessly.
    if (s2_adv) begin
      s2_v_d = s1_v_q;
      if (s1_v_q) begin
        s2_res_d   = core_res;
        s2_flags_d = core_flags;
      end
    end

    if (s2_v_q && out_ready && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q     <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_op_q    <= OP_AND;
      s2_v_q     <= 1'b0;
      s2_res_q   <= '0;
      s2_flags_q <= '0;
      cnt_q      <= '0;
    end else begin
      s1_v_q     <= s1_v_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_op_q    <= s1_op_d;
      s2_v_q     <= s2_v_d;
      s2_res_q   <= s2_res_d;
      s2_flags_q <= s2_flags_d;
      cnt_q      <= cnt_d;
    end
  end

  assign in_ready  = s1_adv;
  assign out_valid = s2_v_q;
  assign out_res   = s2_res_q;
  assign out_zero  = s2_flags_q.zero;
  assign out_neg   = s2_flags_q.neg;
  assign out_par   = s2_flags_q.par;
  assign out_ovf   = s2_flags_q.ovf;
  assign op_count  = cnt_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Testbench for logic_unit_pipe: a 32-bit/16-bit-counter instance checked by
// directed steps plus a scoreboard fed from an arithmetic reference model,
// and an 8-bit/2-bit-counter instance for narrow-width and saturation cases.
module tb_logic_unit_pipe;

  typedef struct packed {
    logic [31:0] res;
    logic        zero;
    logic        neg;
    logic        par;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  // 32-bit instance
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_a, in_b, out_res;
  logic [2:0]  in_op;
  logic        out_zero, out_neg, out_par, out_ovf;
  logic [15:0] op_count;
  // 8-bit instance
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [7:0]  b_in_a, b_in_b, b_out_res;
  logic [2:0]  b_in_op;
  logic        b_out_zero, b_out_neg, b_out_par, b_out_ovf;
  logic [1:0]  b_op_count;

  int errors = 0;
  int checks = 0;

  exp_t        q[$];
  logic [15:0] mcnt;
  logic        stall_prev;
  logic [31:0] held_res;

  always #5 clk = ~clk;

  logic_unit_pipe #(.WIDTH(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_res(out_res), .out_zero(out_zero), .out_neg(out_neg),
    .out_par(out_par), .out_ovf(out_ovf), .op_count(op_count)
  );

  logic_unit_pipe #(.WIDTH(8), .CNT_W(2)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_a(b_in_a), .in_b(b_in_b), .in_op(b_in_op),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_res(b_out_res), .out_zero(b_out_zero), .out_neg(b_out_neg),
    .out_par(b_out_par), .out_ovf(b_out_ovf), .op_count(b_op_count)
  );

  // Reference: result from the opcode meaning, negation as 0 - a, flags
  // taken from the w-bit result.
  function automatic exp_t model(input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input int w);
    exp_t        m;
    logic [31:0] mask;
    logic [31:0] r;
    logic [31:0] am;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    case (op)
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd2: r = a ^ b;
      3'd3: r = ~(a & b);
      3'd4: r = ~(a | b);
      3'd5: r = ~(a ^ b);
      3'd6: r = ~a;
      default: r = 32'd0 - a;
    endcase
    r      = r & mask;
    am     = a & mask;
    m.res  = r;
    m.zero = (r == 32'd0);
    m.neg  = r[w-1];
    m.par  = ^r;
    m.ovf  = (op == 3'd7) && (am == (32'd1 << (w - 1)));
    return m;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard on the 32-bit instance: every output transfer must match the
  // oldest accepted input, the counter must track transfers, and a stalled
  // output must hold.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      mcnt       = 16'd0;
      stall_prev = 1'b0;
    end else begin
      chk("op_count", {16'd0, op_count}, {16'd0, mcnt});
      if (stall_prev) begin
        chk("stall_valid", {31'd0, out_valid}, 32'd1);
        chk("stall_res", out_res, held_res);
      end
      if (out_valid && out_ready) begin
        chk("out_has_entry", {31'd0, (q.size() > 0)}, 32'd1);
        if (q.size() > 0) begin
          exp_t e;
          e = q.pop_front();
          $display("out res=%08h z=%0d n=%0d p=%0d o=%0d exp=%08h", out_res,
                   out_zero, out_neg, out_par, out_ovf, e.res);
          chk("sb_res", out_res, e.res);
          chk("sb_flags", {28'd0, out_zero, out_neg, out_par, out_ovf},
              {28'd0, e.zero, e.neg, e.par, e.ovf});
        end
        if (mcnt != 16'hFFFF) mcnt = mcnt + 16'd1;
      end
      if (in_valid && in_ready) q.push_back(model(in_op, in_a, in_b, 32));
      chk("occupancy", {31'd0, (q.size() <= 2)}, 32'd1);
      stall_prev = out_valid && !out_ready;
      held_res   = out_res;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    in_valid = v;
    in_op    = op;
    in_a     = a;
    in_b     = b;
  endtask

  // One op through an idle pipe with out_ready high; check it two cycles later.
  task automatic single(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] er,
                        input logic [3:0] ef);
    out_ready = 1'b1;
    drive(1'b1, op, a, b);
    tick();
    in_valid = 1'b0;
    tick();
    @(negedge clk);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_res"}, out_res, er);
    chk({tag, "_flags"}, {28'd0, out_zero, out_neg, out_par, out_ovf}, {28'd0, ef});
    tick();
  endtask

  initial begin
    exp_t ea;
    rst = 1'b1;
    drive(1'b0, 3'd0, 32'd0, 32'd0);
    out_ready   = 1'b0;
    b_in_valid  = 1'b0;
    b_in_a      = 8'd0;
    b_in_b      = 8'd0;
    b_in_op     = 3'd0;
    b_out_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_res", out_res, 32'd0);
    chk("rst_flags", {28'd0, out_zero, out_neg, out_par, out_ovf}, 32'd0);
    chk("rst_count8", {30'd0, b_op_count}, 32'd0);
    tick();

    // Directed ops: flags packed as {zero, neg, par, ovf}
    single("and",  3'd0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 4'b0100);
    single("neg1", 3'd7, 32'h0000_0001, 32'h1234_5678, 32'hFFFF_FFFF, 4'b0100);
    single("negmin", 3'd7, 32'h8000_0000, 32'h0, 32'h8000_0000, 4'b0111);
    single("neg0", 3'd7, 32'h0, 32'hFFFF_FFFF, 32'h0, 4'b1000);

    // Backpressure: two accepted, third refused until out_ready rises
    out_ready = 1'b0;
    ea = model(3'd2, 32'h1111_2222, 32'h0F0F_0F0F, 32);
    drive(1'b1, 3'd2, 32'h1111_2222, 32'h0F0F_0F0F);
    @(negedge clk); chk("stall_acc1", {31'd0, in_ready}, 32'd1);
    tick();
    drive(1'b1, 3'd4, 32'h3333_4444, 32'h00FF_00FF);
    @(negedge clk); chk("stall_acc2", {31'd0, in_ready}, 32'd1);
    tick();
    drive(1'b1, 3'd6, 32'h5555_6666, 32'h0);
    @(negedge clk);
    chk("stall_block", {31'd0, in_ready}, 32'd0);
    chk("stall_head", out_res, ea.res);
    tick();
    @(negedge clk); chk("stall_block2", {31'd0, in_ready}, 32'd0);
    tick();
    out_ready = 1'b1;
    @(negedge clk); chk("resume_accept", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    repeat (4) tick();

    // Reset with two entries in flight
    out_ready = 1'b0;
    drive(1'b1, 3'd1, 32'hDEAD_BEEF, 32'h1);
    tick();
    drive(1'b1, 3'd3, 32'hCAFE_F00D, 32'h2);
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk); chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_count", {16'd0, op_count}, 32'd0);
    chk("midrst_res", out_res, 32'd0);
    chk("midrst_ready", {31'd0, in_ready}, 32'd1);
    tick();

    // Eight back-to-back ops: results on consecutive cycles
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 3'(i), 32'hA5A5_A5A5, 32'h0F0F_0F0F);
      @(negedge clk);
      chk("burst_ready", {31'd0, in_ready}, 32'd1);
      if (i >= 2) chk("burst_valid", {31'd0, out_valid}, 32'd1);
      tick();
    end
    in_valid = 1'b0;
    @(negedge clk); chk("burst_tail1", {31'd0, out_valid}, 32'd1);
    tick();
    @(negedge clk); chk("burst_tail2", {31'd0, out_valid}, 32'd1);
    tick();
    @(negedge clk);
    chk("burst_done", {31'd0, out_valid}, 32'd0);
    chk("burst_count", {16'd0, op_count}, 32'd8);
    tick();

    // 8-bit instance: narrow AND/NOT and 2-bit counter saturation
    for (int i = 0; i < 5; i++) begin
      exp_t e8;
      logic [7:0] a8, bb8;
      logic [2:0] op8;
      a8  = (i == 0) ? 8'hF0 : (i == 1) ? 8'h80 : 8'($urandom);
      bb8 = (i == 0) ? 8'h3C : 8'($urandom);
      op8 = (i == 0) ? 3'd0 : (i == 1) ? 3'd6 : 3'($urandom_range(0, 7));
      e8  = model(op8, {24'd0, a8}, {24'd0, bb8}, 8);
      b_in_valid = 1'b1; b_in_op = op8; b_in_a = a8; b_in_b = bb8;
      tick();
      b_in_valid = 1'b0;
      tick();
      @(negedge clk);
      $display("w8 op=%0d a=%02h b=%02h res=%02h exp=%02h", op8, a8, bb8, b_out_res, e8.res[7:0]);
      chk("w8_valid", {31'd0, b_out_valid}, 32'd1);
      chk("w8_res", {24'd0, b_out_res}, e8.res);
      chk("w8_flags", {28'd0, b_out_zero, b_out_neg, b_out_par, b_out_ovf},
          {28'd0, e8.zero, e8.neg, e8.par, e8.ovf});
      if (i == 0) chk("w8_and", {24'd0, b_out_res}, 32'h30);
      if (i == 1) chk("w8_not", {24'd0, b_out_res}, 32'h7F);
      tick();
      @(negedge clk);
      chk("w8_count", {30'd0, b_op_count}, (i + 1 > 3) ? 32'd3 : 32'(i + 1));
      tick();
    end

    // Random traffic on the 32-bit instance, checked by the scoreboard
    for (int i = 0; i < 300; i++) begin
      logic [31:0] ra;
      case ($urandom_range(0, 5))
        0: ra = 32'h8000_0000;
        1: ra = 32'h0;
        default: ra = $urandom;
      endcase
      drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), ra, $urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();
    @(negedge clk);
    chk("drain_empty", q.size(), 32'd0);
    chk("drain_valid", {31'd0, out_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
